// File: rtl/draw_pkg.sv
// Shared types and constants for the draw sequencer slice.
// State encodings, the erase colour and default pixel widths.
package draw_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_GO,
    S_DRAW,
    S_NEXT,
    S_LOGIC,
    S_LOGIC_WAIT,
    S_INC,
    S_SWAP
  } state_t;

  localparam int DEF_XW = 10;
  localparam int DEF_YW = 10;
  localparam int DEF_CW = 3;

  localparam logic [DEF_CW-1:0] BLACK = '0;

endpackage

// File: rtl/draw_channel_mux.sv
// NUM_CH-to-1 pixel selector feeding the VGA writer.
// Erase pass forces BLACK; writes only pass through while drawing.
module draw_channel_mux
  import draw_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int XW     = DEF_XW,
  parameter int YW     = DEF_YW,
  parameter int CW     = DEF_CW,
  parameter int AW     = 2
) (
  input  logic [AW-1:0]        i_sel,
  input  logic                 i_draw,
  input  logic                 i_iscolour,
  input  logic [NUM_CH*XW-1:0] i_x,
  input  logic [NUM_CH*YW-1:0] i_y,
  input  logic [NUM_CH*CW-1:0] i_colour,
  input  logic [NUM_CH-1:0]    i_we,
  output logic [XW-1:0]        o_x,
  output logic [YW-1:0]        o_y,
  output logic [CW-1:0]        o_colour,
  output logic                 o_we
);

  logic [CW-1:0] w_col;

  always_comb begin
    o_x   = i_x[int'(i_sel)*XW +: XW];
    o_y   = i_y[int'(i_sel)*YW +: YW];
    w_col = i_colour[int'(i_sel)*CW +: CW];
    o_colour = i_iscolour ? w_col : CW'(BLACK);
    o_we  = i_we[i_sel] & i_draw;
  end

endmodule

// File: rtl/draw_sequencer.sv
// Frame sequencer: erase pass, game logic, inc, colour pass.
// Each channel runs a go/done handshake bounded by a timeout.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int XW            = DEF_XW,
  parameter int YW            = DEF_YW,
  parameter int CW            = DEF_CW,
  parameter int TIMEOUT       = 4095,
  parameter int LOGIC_TIMEOUT = 31,
  parameter int CNT_W         = 20,
  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_en,
  input  logic                 hold,
  input  logic [NUM_CH-1:0]    erase_mask,
  input  logic [NUM_CH-1:0]    colour_mask,
  input  logic [NUM_CH*XW-1:0] ch_x,
  input  logic [NUM_CH*YW-1:0] ch_y,
  input  logic [NUM_CH*CW-1:0] ch_colour,
  input  logic [NUM_CH-1:0]    ch_we,
  input  logic [NUM_CH-1:0]    ch_done,
  input  logic                 logic_done,
  output logic [NUM_CH-1:0]    ch_go,
  output logic                 logic_go,
  output logic                 inc_enable,
  output logic                 iscolour,
  output logic                 busy,
  output logic [AW-1:0]        active_ch,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic [CW-1:0]        colour,
  output logic                 writeEn,
  output logic [NUM_CH:0]      timeout_err,
  output logic                 frame_overrun
);

  state_t              r_state;
  logic                r_iscolour;
  logic [AW-1:0]       r_active;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_CH:0]     r_err;
  logic                r_overrun;

  logic [NUM_CH-1:0]   w_mask;
  logic                w_found;
  logic [AW-1:0]       w_idx;
  logic                w_last;
  logic                w_sat;
  state_t              w_nochan;

  assign w_mask   = r_iscolour ? colour_mask : erase_mask;
  assign w_last   = (r_active == AW'(NUM_CH-1));
  assign w_sat    = &r_cnt;
  assign w_nochan = r_iscolour ? S_SWAP : S_LOGIC;

  // Single-cycle priority scan from the current channel upward.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (w_mask[i] && (i >= int'(r_active))) begin
        w_found = 1'b1;
        w_idx   = AW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_iscolour <= 1'b0;
      r_active   <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (frame_en && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (frame_en && !hold) begin
            r_state    <= S_SCAN;
            r_iscolour <= 1'b0;
            r_active   <= '0;
          end
        end
        S_SCAN: begin
          if (w_found) begin
            r_active <= w_idx;
            r_state  <= S_GO;
          end else begin
            r_state <= w_nochan;
          end
        end
        S_GO: begin
          r_cnt   <= '0;
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          if (ch_done[r_active]) begin
            r_state <= S_NEXT;
          end else if (r_cnt >= CNT_W'(TIMEOUT)) begin
            r_err[r_active] <= 1'b1;
            r_state <= S_NEXT;
          end else if (!w_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (w_last) begin
            r_state <= w_nochan;
          end else begin
            r_active <= r_active + 1'b1;
            r_state  <= S_SCAN;
          end
        end
        S_LOGIC: begin
          r_cnt   <= '0;
          r_state <= S_LOGIC_WAIT;
        end
        S_LOGIC_WAIT: begin
          if (logic_done) begin
            r_state <= S_INC;
          end else if (r_cnt >= CNT_W'(LOGIC_TIMEOUT)) begin
            r_err[NUM_CH] <= 1'b1;
            r_state <= S_INC;
          end else if (!w_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_INC: r_state <= S_SWAP;
        S_SWAP: begin
          r_iscolour <= ~r_iscolour;
          r_active   <= '0;
          r_state    <= r_iscolour ? S_IDLE : S_SCAN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_go = (r_state == S_GO)
               ? (NUM_CH'(1) << r_active) : '0;
  assign logic_go      = (r_state == S_LOGIC);
  assign inc_enable    = (r_state == S_INC);
  assign iscolour      = r_iscolour;
  assign busy          = (r_state != S_IDLE);
  assign active_ch     = r_active;
  assign timeout_err   = r_err;
  assign frame_overrun = r_overrun;

  draw_channel_mux #(
    .NUM_CH (NUM_CH),
    .XW     (XW),
    .YW     (YW),
    .CW     (CW),
    .AW     (AW)
  ) u_mux (
    .i_sel      (r_active),
    .i_draw     (r_state == S_DRAW),
    .i_iscolour (r_iscolour),
    .i_x        (ch_x),
    .i_y        (ch_y),
    .i_colour   (ch_colour),
    .i_we       (ch_we),
    .o_x        (x),
    .o_y        (y),
    .o_colour   (colour),
    .o_we       (writeEn)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: go/logic/inc event order,
// frame lengths, pixel mux contents, sticky flags and reset.
module tb_draw_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_en = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  erase_mask = '0;
  logic [2:0]  colour_mask = '0;
  logic [29:0] ch_x;
  logic [29:0] ch_y;
  logic [8:0]  ch_colour;
  logic [2:0]  ch_we = 3'b111;
  logic [2:0]  ch_done = '0;
  logic        logic_done = 1'b0;
  logic [2:0]  ch_go;
  logic        logic_go;
  logic        inc_enable;
  logic        iscolour;
  logic        busy;
  logic [1:0]  active_ch;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic [3:0]  timeout_err;
  logic        frame_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int dly[3];
  int ldly;
  int cd[3];
  int lcd;
  int mon_ch = 0;
  bit mon_colour = 1'b0;

  localparam int EV_LOGIC = 10;
  localparam int EV_INC   = 11;

  draw_sequencer #(
    .NUM_CH(3), .XW(10), .YW(10), .CW(3),
    .TIMEOUT(31), .LOGIC_TIMEOUT(31), .CNT_W(20)
  ) dut (
    .clk(clk), .resetn(resetn),
    .frame_en(frame_en), .hold(hold),
    .erase_mask(erase_mask),
    .colour_mask(colour_mask),
    .ch_x(ch_x), .ch_y(ch_y),
    .ch_colour(ch_colour), .ch_we(ch_we),
    .ch_done(ch_done), .logic_done(logic_done),
    .ch_go(ch_go), .logic_go(logic_go),
    .inc_enable(inc_enable), .iscolour(iscolour),
    .busy(busy), .active_ch(active_ch),
    .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .timeout_err(timeout_err),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  function automatic int xv(input int i);
    return 100 + 37 * i;
  endfunction
  function automatic int yv(input int i);
    return 200 + 11 * i;
  endfunction
  function automatic int cv(input int i);
    return 5 + i;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int ev);
    int e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL event: got %0d expected none", ev);
    end else begin
      e = exp_q.pop_front();
      chk("event", ev, e);
    end
  endtask

  // Channel and game-logic responders: done pulses after a delay.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      ch_done[i] = 1'b0;
      if (!resetn) cd[i] = 0;
      else if (ch_go[i]) cd[i] = dly[i];
      else if (cd[i] > 0) begin
        cd[i]--;
        if (cd[i] == 0) ch_done[i] = 1'b1;
      end
    end
    logic_done = 1'b0;
    if (!resetn) lcd = 0;
    else if (logic_go) lcd = ldly;
    else if (lcd > 0) begin
      lcd--;
      if (lcd == 0) logic_done = 1'b1;
    end
  end

  // Monitor: pops expected events and checks every pixel write.
  always @(negedge clk) begin
    if (resetn) begin
      for (int i = 0; i < 3; i++)
        if (ch_go[i]) begin
          expect_ev(i);
          mon_ch = i;
        end
      if (logic_go) expect_ev(EV_LOGIC);
      if (inc_enable) begin
        expect_ev(EV_INC);
        mon_colour = 1'b1;
      end
      if (writeEn) begin
        chk("wr_x", x, xv(mon_ch));
        chk("wr_y", y, yv(mon_ch));
        chk("wr_colour", colour,
            mon_colour ? cv(mon_ch) : 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    frame_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    mon_colour = 1'b0;
  endtask

  task automatic run_frame(input string nm,
                           output int nb,
                           output int lgc,
                           output int incc,
                           output int nw);
    bit fin;
    mon_colour = 1'b0;
    frame_en = 1'b1;
    @(posedge clk);
    #1 frame_en = 1'b0;
    nb = 0; lgc = -1; incc = -1; nw = 0; fin = 0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge clk);
      if (!busy) fin = 1;
      else begin
        nb++;
        if (logic_go && lgc < 0) lgc = c;
        if (inc_enable && incc < 0) incc = c;
        if (writeEn) nw++;
      end
    end
    if (!fin) chk({nm, "_finish"}, 0, 1);
    chk({nm, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    int nb, lgc, incc, nw;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      ch_x[i*10 +: 10] = 10'(xv(i));
      ch_y[i*10 +: 10] = 10'(yv(i));
      ch_colour[i*3 +: 3] = 3'(cv(i));
      dly[i] = 4;
    end
    ldly = 2;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ctrl",
        {busy, iscolour, active_ch, ch_go, logic_go,
         inc_enable, writeEn}, 0);
    chk("rst_sticky", {timeout_err, frame_overrun}, 0);

    // Basic frame
    erase_mask = 3'b101;
    colour_mask = 3'b111;
    exp_q = '{0, 2, EV_LOGIC, EV_INC, 0, 1, 2};
    run_frame("basic", nb, lgc, incc, nw);
    chk("basic_busy", nb, 41);
    chk("basic_lgo", lgc, 15);
    chk("basic_inc", incc, 18);
    chk("basic_writes", nw, 20);
    chk("basic_err", timeout_err, 0);
    chk("basic_iscol", iscolour, 0);

    // Channel 1 never answers
    do_reset();
    erase_mask = 3'b110;
    colour_mask = 3'b000;
    dly = '{4, 0, 4};
    exp_q = '{1, 2, EV_LOGIC, EV_INC};
    run_frame("tmo", nb, lgc, incc, nw);
    chk("tmo_busy", nb, 49);
    chk("tmo_writes", nw, 36);
    chk("tmo_lgo", lgc, 43);
    chk("tmo_err", timeout_err, 4'b0010);

    // Empty masks
    do_reset();
    erase_mask = 3'b000;
    dly = '{4, 4, 4};
    ldly = 1;
    exp_q = '{EV_LOGIC, EV_INC};
    run_frame("empty", nb, lgc, incc, nw);
    chk("empty_busy", nb, 7);
    chk("empty_lgo", lgc, 2);
    chk("empty_inc", incc, 4);
    chk("empty_writes", nw, 0);

    // Hold blocks start, no overrun
    do_reset();
    hold = 1'b1;
    frame_en = 1'b1;
    @(posedge clk);
    #1 frame_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_busy", busy, 0);
    chk("hold_ovr", frame_overrun, 0);
    hold = 1'b0;

    // Overrun: second tick mid-frame is dropped
    exp_q = '{EV_LOGIC, EV_INC};
    mon_colour = 1'b0;
    frame_en = 1'b1;
    @(posedge clk);
    #1 frame_en = 1'b0;
    @(posedge clk);
    #1 frame_en = 1'b1;
    @(posedge clk);
    #1 frame_en = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    chk("ovr_idle", seen, 1);
    chk("ovr_flag", frame_overrun, 1);
    repeat (5) @(negedge clk);
    chk("ovr_nostart", busy, 0);
    chk("ovr_queue", exp_q.size(), 0);

    // Reset during ch1 DRAW
    do_reset();
    ldly = 2;
    erase_mask = 3'b111;
    dly = '{4, 20, 4};
    exp_q = '{0, 1};
    mon_colour = 1'b0;
    frame_en = 1'b1;
    @(posedge clk);
    #1 frame_en = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (ch_go[1]) seen = 1;
    end
    chk("rmid_go1", seen, 1);
    repeat (3) @(negedge clk);
    chk("rmid_draw", writeEn, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rmid_ctrl",
        {busy, iscolour, active_ch, ch_go, logic_go,
         inc_enable, writeEn}, 0);
    chk("rmid_sticky", {timeout_err, frame_overrun}, 0);
    @(negedge clk);
    resetn = 1'b1;
    chk("rmid_queue", exp_q.size(), 0);
    erase_mask = 3'b001;
    colour_mask = 3'b000;
    dly = '{4, 4, 4};
    exp_q = '{0, EV_LOGIC, EV_INC};
    run_frame("rmid_next", nb, lgc, incc, nw);
    chk("rmid_busy", nb, 15);
    chk("rmid_writes", nw, 4);

    // Done exactly at the timeout count
    do_reset();
    dly = '{32, 4, 4};
    exp_q = '{0, EV_LOGIC, EV_INC};
    run_frame("tie", nb, lgc, incc, nw);
    chk("tie_busy", nb, 43);
    chk("tie_writes", nw, 32);
    chk("tie_err", timeout_err, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
